// File: rtl/game_pkg.sv
// Shared game definitions for the whack-a-mole datapath.
// Used by the scheduler, its bus interface, and the I/O and display blocks.
//   state_t   : game sequencer state (IDLE, GAP, SHOW, DONE)
//   HOLE_W    : width of a hole index
//   NUM_HOLES : number of holes (one-hot mole display width)
//   SCORE_W   : width of the hit and miss counts
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int HOLE_W    = 3;
    localparam int NUM_HOLES = 8;
    localparam int SCORE_W   = 8;

    // Never raise the mole in the same hole twice in a row: step to the next hole.
    function automatic logic [HOLE_W-1:0] pick_hole(input logic [HOLE_W-1:0] rnd,
                                                    input logic [HOLE_W-1:0] prev);
        return (rnd == prev) ? rnd + HOLE_W'(1) : rnd;
    endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Bus between the mole scheduler and its surroundings (random8 source,
// button front-end, LED display).
//   start/stop        : round control
//   rnd_data          : free-running random byte
//   hit_valid/hit_hole: player strike
//   mole              : one-hot raised mole
//   hit/miss/wrong_pulse, score, misses, done : game results
// modport slave  : the scheduler
// modport master : the environment driving it
interface mole_scheduler_if;
    import game_pkg::*;

    logic                 start;
    logic                 stop;
    logic [7:0]           rnd_data;
    logic                 hit_valid;
    logic [HOLE_W-1:0]    hit_hole;
    logic [NUM_HOLES-1:0] mole;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 wrong_pulse;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic                 done;

    modport master (
        output start, stop, rnd_data, hit_valid, hit_hole,
        input  mole, hit_pulse, miss_pulse, wrong_pulse, score, misses, done
    );

    modport slave (
        input  start, stop, rnd_data, hit_valid, hit_hole,
        output mole, hit_pulse, miss_pulse, wrong_pulse, score, misses, done
    );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter that stops at zero.
//   clock, resetn : clock, asynchronous active-low reset
//   load          : load load_value this edge (takes priority over counting)
//   load_value    : value to load
//   zero          : counter currently reads zero
module countdown_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer. Picks holes and gaps from the random byte,
// drives the one-hot mole display, judges strikes and keeps the round score.
//   clock, resetn : clock, asynchronous active-low reset
//   bus (slave)   : start/stop, rnd_data, hit_valid/hit_hole in;
//                   mole, hit/miss/wrong pulses, score, misses, done out
// All outputs are registered. One countdown timer serves both the GAP and
// SHOW phases since they never overlap.
module mole_scheduler
    import game_pkg::*;
#(
    parameter int GAP_BASE    = 1000,
    parameter int GAP_SHIFT   = 6,
    parameter int SHOW_CYCLES = 5000,
    parameter int MAX_MISSES  = 5,
    parameter int CNT_W       = 24
) (
    input  logic        clock,
    input  logic        resetn,
    mole_scheduler_if.slave bus
);

    state_t               state, state_nxt;
    logic [HOLE_W-1:0]    prev_hole, prev_hole_nxt, new_hole;
    logic [NUM_HOLES-1:0] mole_q, mole_nxt;
    logic                 hit_q, hit_nxt, miss_q, miss_nxt, wrong_q, wrong_nxt, done_q;
    logic [SCORE_W-1:0]   score_q, score_nxt, misses_q, misses_nxt;
    logic                 t_load, t_zero;
    logic [CNT_W-1:0]     t_value;
    logic                 hit_ok, last_miss;

    function automatic logic [CNT_W-1:0] gap_load(input logic [7:0] rnd);
        return CNT_W'(GAP_BASE) + (CNT_W'(rnd[7:3]) << GAP_SHIFT);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic [SCORE_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

    // prev_hole doubles as the hole currently raised while in SHOW.
    assign new_hole  = pick_hole(bus.rnd_data[HOLE_W-1:0], prev_hole);
    assign hit_ok    = bus.hit_valid && (bus.hit_hole == prev_hole);
    assign last_miss = (misses_q == SCORE_W'(MAX_MISSES - 1));

    countdown_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (t_load),
        .load_value (t_value),
        .zero       (t_zero)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) state_nxt = GAP;
                GAP:        if (t_zero) state_nxt = SHOW;
                SHOW: begin
                    if (hit_ok)      state_nxt = GAP;
                    else if (t_zero) state_nxt = last_miss ? DONE : GAP;
                end
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mole_nxt      = mole_q;
        prev_hole_nxt = prev_hole;
        score_nxt     = score_q;
        misses_nxt    = misses_q;
        hit_nxt       = 1'b0;
        miss_nxt      = 1'b0;
        wrong_nxt     = 1'b0;
        t_load        = 1'b0;
        t_value       = '0;
        if (bus.stop) begin
            // Abort: clear the timer, keep the counts for display.
            mole_nxt = '0;
            t_load   = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        score_nxt  = '0;
                        misses_nxt = '0;
                        mole_nxt   = '0;
                        t_load     = 1'b1;
                        t_value    = gap_load(bus.rnd_data);
                    end
                end
                GAP: begin
                    wrong_nxt = bus.hit_valid;
                    if (t_zero) begin
                        prev_hole_nxt = new_hole;
                        mole_nxt      = {{(NUM_HOLES-1){1'b0}}, 1'b1} << new_hole;
                        t_load        = 1'b1;
                        t_value       = CNT_W'(SHOW_CYCLES - 1);
                    end
                end
                SHOW: begin
                    if (hit_ok) begin
                        // A correct strike on the timeout cycle still counts as a hit.
                        hit_nxt   = 1'b1;
                        score_nxt = sat_inc(score_q, {SCORE_W{1'b1}});
                        mole_nxt  = '0;
                        t_load    = 1'b1;
                        t_value   = gap_load(bus.rnd_data);
                    end else begin
                        wrong_nxt = bus.hit_valid;
                        if (t_zero) begin
                            miss_nxt   = 1'b1;
                            misses_nxt = sat_inc(misses_q, SCORE_W'(MAX_MISSES));
                            mole_nxt   = '0;
                            if (!last_miss) begin
                                t_load  = 1'b1;
                                t_value = gap_load(bus.rnd_data);
                            end
                        end
                    end
                end
                default: mole_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mole_q    <= '0;
            prev_hole <= '0;
            score_q   <= '0;
            misses_q  <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            wrong_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mole_q    <= mole_nxt;
            prev_hole <= prev_hole_nxt;
            score_q   <= score_nxt;
            misses_q  <= misses_nxt;
            hit_q     <= hit_nxt;
            miss_q    <= miss_nxt;
            wrong_q   <= wrong_nxt;
            done_q    <= (state_nxt == DONE);
        end
    end

    assign bus.mole        = mole_q;
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;
    assign bus.wrong_pulse = wrong_q;
    assign bus.score       = score_q;
    assign bus.misses      = misses_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed scenarios followed by a
// randomized run, all compared against a behavioural game model.
module tb_mole_scheduler;
    import game_pkg::*;

    localparam int GB = 4;
    localparam int GS = 6;
    localparam int SC = 3;
    localparam int MM = 5;
    localparam int CW = 16;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_SHOW = 2;
    localparam int P_DONE = 3;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    mole_scheduler_if bus();

    mole_scheduler #(
        .GAP_BASE(GB), .GAP_SHIFT(GS), .SHOW_CYCLES(SC), .MAX_MISSES(MM), .CNT_W(CW)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model of the game, in terms of "cycles left" in each phase.
    int m_phase, m_gap_left, m_show_left, m_prev, m_mole;
    int m_score, m_misses, m_done, m_hit, m_miss, m_wrong;

    function automatic int gap_cycles(input logic [7:0] r);
        return GB + int'(r[7:3]) * (1 << GS) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_gap_left = 0; m_show_left = 0; m_prev = 0; m_mole = 0;
        m_score = 0; m_misses = 0; m_done = 0; m_hit = 0; m_miss = 0; m_wrong = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented now.
    task automatic model_step();
        int h;
        m_hit = 0; m_miss = 0; m_wrong = 0;
        if (bus.stop) begin
            m_phase = P_IDLE; m_mole = 0; m_done = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (bus.start) begin
                    m_phase = P_GAP; m_score = 0; m_misses = 0; m_done = 0; m_mole = 0;
                    m_gap_left = gap_cycles(bus.rnd_data);
                end
                P_GAP: begin
                    if (bus.hit_valid) m_wrong = 1;
                    m_gap_left--;
                    if (m_gap_left == 0) begin
                        h = int'(bus.rnd_data) % 8;
                        if (h == m_prev) h = (h + 1) % 8;
                        m_prev = h; m_mole = 1 << h;
                        m_show_left = SC; m_phase = P_SHOW;
                    end
                end
                default: begin
                    if (bus.hit_valid && int'(bus.hit_hole) == m_prev) begin
                        m_hit = 1; m_mole = 0;
                        if (m_score < 255) m_score++;
                        m_gap_left = gap_cycles(bus.rnd_data); m_phase = P_GAP;
                    end else begin
                        if (bus.hit_valid) m_wrong = 1;
                        m_show_left--;
                        if (m_show_left == 0) begin
                            m_miss = 1; m_mole = 0;
                            if (m_misses < MM) m_misses++;
                            if (m_misses == MM) begin
                                m_phase = P_DONE; m_done = 1;
                            end else begin
                                m_gap_left = gap_cycles(bus.rnd_data); m_phase = P_GAP;
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("mole",   32'(bus.mole),        32'(m_mole));
        chk("hit",    32'(bus.hit_pulse),   32'(m_hit));
        chk("miss",   32'(bus.miss_pulse),  32'(m_miss));
        chk("wrong",  32'(bus.wrong_pulse), 32'(m_wrong));
        chk("score",  32'(bus.score),       32'(m_score));
        chk("misses", 32'(bus.misses),      32'(m_misses));
        chk("done",   32'(bus.done),        32'(m_done));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.stop = 1'b0; bus.hit_valid = 1'b0; bus.hit_hole = '0;
    endtask

    task automatic wait_phase(input int ph, input string tag);
        int n = 0;
        while (m_phase != ph && n < 3000) begin
            cyc();
            n++;
        end
        chk({tag, "_reached"}, 32'(m_phase == ph), 32'd1);
    endtask

    initial begin
        int nhits;
        idle_inputs();
        bus.rnd_data = 8'h00;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mole",  32'(bus.mole), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_pulse", 32'({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse}), 32'd0);
        resetn = 1'b1;
        cyc();

        // Start: gap = 4 + (1<<6) = 68, so mole 0 for 69 cycles, then hole 3.
        bus.rnd_data = 8'h0B;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (68) cyc();
        chk("gap_quiet", 32'(bus.mole), 32'd0);
        cyc();
        chk("first_mole", 32'(bus.mole), 32'h08);

        // Correct hit on hole 3.
        bus.hit_valid = 1'b1; bus.hit_hole = 3'd3;
        cyc();
        chk("hit_pulse", 32'(bus.hit_pulse), 32'd1);
        chk("hit_score", 32'(bus.score), 32'd1);
        chk("hit_mole",  32'(bus.mole), 32'd0);
        idle_inputs();
        cyc();
        chk("hit_one_cycle", 32'(bus.hit_pulse), 32'd0);

        // Same random hole again steps to hole 4.
        repeat (67) cyc();
        chk("gap2_quiet", 32'(bus.mole), 32'd0);
        cyc();
        chk("repeat_hole", 32'(bus.mole), 32'h10);

        // Wrong hole, then correct hit exactly on the timeout cycle.
        bus.hit_valid = 1'b1; bus.hit_hole = 3'd1;
        cyc();
        chk("wrong_pulse", 32'(bus.wrong_pulse), 32'd1);
        chk("wrong_nohit", 32'(bus.hit_pulse), 32'd0);
        chk("wrong_mole",  32'(bus.mole), 32'h10);
        idle_inputs();
        cyc();
        bus.hit_valid = 1'b1; bus.hit_hole = 3'd4;
        cyc();
        chk("race_hit",  32'(bus.hit_pulse), 32'd1);
        chk("race_miss", 32'(bus.miss_pulse), 32'd0);
        chk("race_score", 32'(bus.score), 32'd2);
        idle_inputs();

        // rnd[2:0]=7 twice: hole 7, then hole 0.
        bus.rnd_data = 8'h07;
        wait_phase(P_SHOW, "show7");
        chk("hole7", 32'(bus.mole), 32'h80);
        repeat (SC) cyc();
        chk("miss_pulse", 32'(bus.miss_pulse), 32'd1);
        chk("miss_count", 32'(bus.misses), 32'd1);
        wait_phase(P_SHOW, "show0");
        chk("wrap_hole", 32'(bus.mole), 32'h01);
        bus.start = 1'b1;
        cyc();
        chk("start_ignored", 32'(bus.mole), 32'h01);
        bus.start = 1'b0;
        wait_phase(P_DONE, "done");
        chk("done_flag",   32'(bus.done), 32'd1);
        chk("done_misses", 32'(bus.misses), 32'd5);
        chk("done_mole",   32'(bus.mole), 32'd0);
        repeat (3) cyc();
        chk("done_frozen", 32'(bus.score), 32'd2);

        // Restart from DONE, score one hit, then stop mid-SHOW.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("restart_done",   32'(bus.done), 32'd0);
        chk("restart_score",  32'(bus.score), 32'd0);
        chk("restart_misses", 32'(bus.misses), 32'd0);
        wait_phase(P_SHOW, "show_a");
        bus.hit_valid = 1'b1; bus.hit_hole = 3'(m_prev);
        cyc();
        idle_inputs();
        wait_phase(P_SHOW, "show_b");
        cyc();
        bus.stop = 1'b1;
        cyc();
        chk("stop_mole",  32'(bus.mole), 32'd0);
        chk("stop_score", 32'(bus.score), 32'd1);
        // stop and start together: stop wins.
        bus.start = 1'b1;
        cyc();
        idle_inputs();
        repeat (80) cyc();
        chk("stop_wins", 32'(bus.mole), 32'd0);

        // Async reset in the middle of GAP.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (3) cyc();
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_mole",  32'(bus.mole), 32'd0);
        chk("areset_score", 32'(bus.score), 32'd0);
        chk("areset_pulse", 32'({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse}), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (5) cyc();

        // Score saturation: hit every mole until past 255 hits.
        bus.rnd_data = 8'h00;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        nhits = 0;
        for (int i = 0; i < 4000 && nhits < 257; i++) begin
            bus.rnd_data  = 8'($urandom_range(0, 7));
            bus.hit_valid = (m_phase == P_SHOW);
            bus.hit_hole  = 3'(m_prev);
            cyc();
            if (m_hit != 0) nhits++;
        end
        idle_inputs();
        chk("sat_hits",  32'(nhits), 32'd257);
        chk("sat_score", 32'(bus.score), 32'd255);

        // Randomized play against the model.
        for (int i = 0; i < 5000; i++) begin
            bus.start     = ($urandom_range(0, 49) == 0);
            bus.stop      = ($urandom_range(0, 299) == 0);
            bus.rnd_data  = 8'(($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
            bus.hit_valid = ($urandom_range(0, 4) == 0);
            bus.hit_hole  = (m_phase == P_SHOW && $urandom_range(0, 1) == 1)
                            ? 3'(m_prev) : 3'($urandom_range(0, 7));
            cyc();
        end
        idle_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
